// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampling UART receiver.
// Receiver state encoding is fixed at 3 bits so both parity builds share it.
package uart_pkg;

  localparam int UART_DATA_BITS_DEF  = 8;
  localparam int UART_OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line, reset to idle-high,
// with a registered falling-edge strobe aligned to the synchronized level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;

  // fall rises on the same edge that rx_s drops to 0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      fall <= 1'b0;
    end else begin
      meta <= rx;
      rx_s <= meta;
      fall <= rx_s & ~meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, configurable data/stop width,
// glitch-start rejection, framing/break reporting. Optional parity: UART_RX_PARITY_EN.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_ZERO = TW'(0);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_SENSE = 1'(PARITY_ODD);

  rx_state_e            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 seen_one;
  logic                 stop_low;
  logic                 rx_s;
  logic                 fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .fall    (fall)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  logic unused_par;
  assign unused_par = PAR_SENSE;
`endif

  // Receiver FSM; seen_one tracks any 1 on the line so break = all-zero frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      tick_cnt   <= TICK_ZERO;
      bit_cnt    <= BIT_ZERO;
      shift      <= '0;
      seen_one   <= 1'b0;
      stop_low   <= 1'b0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            tick_cnt <= TICK_ZERO;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= TICK_ZERO;
              if (rx_s) begin
                state <= IDLE;
              end else begin
                bit_cnt  <= BIT_ZERO;
                seen_one <= 1'b0;
                stop_low <= 1'b0;
`ifdef UART_RX_PARITY_EN
                par_bad  <= 1'b0;
`endif
                state    <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= TICK_ZERO;
              shift    <= {rx_s, shift[DATA_BITS-1:1]};
              seen_one <= seen_one | rx_s;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= BIT_ZERO;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BIT_ONE;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= TICK_ZERO;
              par_bad  <= rx_s ^ (^shift) ^ PAR_SENSE;
              seen_one <= seen_one | rx_s;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= TICK_ZERO;
              if (bit_cnt == STOP_LAST) begin
                bit_cnt <= BIT_ZERO;
                if (!(seen_one | rx_s)) begin
                  break_det <= 1'b1;
                  state     <= WAIT_HIGH;
                end else begin
                  rx_valid  <= 1'b1;
                  data_out  <= shift;
                  frame_err <= stop_low | ~rx_s;
`ifdef UART_RX_PARITY_EN
                  parity_err <= par_bad;
`endif
                  state     <= (stop_low | ~rx_s) ? WAIT_HIGH : IDLE;
                end
              end else begin
                bit_cnt  <= bit_cnt + BIT_ONE;
                stop_low <= stop_low | ~rx_s;
                seen_one <= seen_one | rx_s;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= TICK_ZERO;
          bit_cnt  <= BIT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 instance and a 9-bit/2-stop instance.
// Parity frames are exercised only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int OS      = 16;
  localparam int TDIV    = 4;
  localparam int BIT_CLK = OS * TDIV;

  logic clk = 1'b0;
  logic tick = 1'b0;
  logic reset_n8, reset_n9, rx8, rx9;
  logic [7:0] data_out8;
  logic [8:0] data_out9;
  logic rx_valid8, frame_err8, parity_err8, break_det8;
  logic rx_valid9, frame_err9, parity_err9, break_det9;

  int checks = 0;
  int failures = 0;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_ODD(0)) u8 (
    .clk(clk), .reset_n(reset_n8), .rx(rx8), .tick(tick),
    .data_out(data_out8), .rx_valid(rx_valid8), .frame_err(frame_err8),
    .parity_err(parity_err8), .break_det(break_det8));

  uart_rx_os #(.DATA_BITS(9), .OVERSAMPLE(OS), .STOP_BITS(2), .PARITY_ODD(0)) u9 (
    .clk(clk), .reset_n(reset_n9), .rx(rx9), .tick(tick),
    .data_out(data_out9), .rx_valid(rx_valid9), .frame_err(frame_err9),
    .parity_err(parity_err9), .break_det(break_det9));

  always #5 clk = ~clk;

  // one-clk tick every TDIV clocks, changed just after the rising edge
  initial begin
    int div = 0;
    forever begin
      @(posedge clk);
      #1;
      div  = (div + 1) % TDIV;
      tick = (div == 0);
    end
  end

  int v8 = 0, b8 = 0, long8 = 0, late8 = 0, stray8 = 0;
  int v9 = 0, b9 = 0, long9 = 0, stray9 = 0;
  logic fe8 = 1'b0, pe8 = 1'b0, fe9 = 1'b0, pv8 = 1'b0, pv9 = 1'b0, ptick = 1'b0;

  // pulse monitors sampled on the falling edge
  always @(negedge clk) begin
    ptick <= tick;
    pv8   <= rx_valid8;
    pv9   <= rx_valid9;
    if (rx_valid8) begin
      v8  <= v8 + 1;
      fe8 <= frame_err8;
      pe8 <= parity_err8;
      if (!ptick) late8 <= late8 + 1;
      if (pv8) long8 <= long8 + 1;
    end
    if (rx_valid9) begin
      v9  <= v9 + 1;
      fe9 <= frame_err9;
      if (pv9) long9 <= long9 + 1;
    end
    if (break_det8) b8 <= b8 + 1;
    if (break_det9) b9 <= b9 + 1;
    if (!rx_valid8 && (frame_err8 || parity_err8)) stray8 <= stray8 + 1;
    if (!rx_valid9 && (frame_err9 || parity_err9)) stray9 <= stray9 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int tgt, input logic v, input int nclk);
    if (tgt == 8) rx8 = v;
    else rx9 = v;
    repeat (nclk) @(posedge clk);
    #1;
  endtask

  task automatic send(input int tgt, input int nbits, input logic [8:0] word,
                      input logic par, input int nstop, input logic [1:0] stops);
    drive(tgt, 1'b0, BIT_CLK);
    for (int i = 0; i < nbits; i++) drive(tgt, word[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    drive(tgt, par, BIT_CLK);
`else
    if (par === 1'bz) drive(tgt, 1'b1, 1);
`endif
    for (int i = 0; i < nstop; i++) drive(tgt, stops[i], BIT_CLK);
  endtask

  function automatic logic even_par(input logic [8:0] w);
    return ^w;
  endfunction

  initial begin
    rx8 = 1'b1;
    rx9 = 1'b1;
    reset_n8 = 1'b0;
    reset_n9 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data8", data_out8, 32'h0);
    check("rst_valid8", rx_valid8, 32'h0);
    check("rst_ferr8", frame_err8, 32'h0);
    check("rst_perr8", parity_err8, 32'h0);
    check("rst_brk8", break_det8, 32'h0);
    check("rst_data9", data_out9, 32'h0);
    reset_n8 = 1'b1;
    reset_n9 = 1'b1;
    drive(8, 1'b1, 2 * BIT_CLK);

    // 8N1 0xA5
    send(8, 8, 9'h0A5, even_par(9'h0A5), 1, 2'b11);
    drive(8, 1'b1, BIT_CLK);
    check("a5_count", v8, 32'd1);
    check("a5_data", data_out8, 32'hA5);
    check("a5_ferr", fe8, 32'h0);
    check("a5_perr", pe8, 32'h0);
    check("a5_after_tick", late8, 32'h0);
    check("a5_width", long8, 32'h0);

    // glitch of 5 ticks, then a clean 0x3C
    drive(8, 1'b0, 5 * TDIV);
    drive(8, 1'b1, 3 * BIT_CLK);
    check("glitch_no_valid", v8, 32'd1);
    send(8, 8, 9'h03C, even_par(9'h03C), 1, 2'b11);
    drive(8, 1'b1, BIT_CLK);
    check("3c_count", v8, 32'd2);
    check("3c_data", data_out8, 32'h3C);
    check("3c_ferr", fe8, 32'h0);

    // 0x55 with stop low, line held low afterwards
    send(8, 8, 9'h055, even_par(9'h055), 1, 2'b00);
    check("ferr_count", v8, 32'd3);
    check("ferr_data", data_out8, 32'h55);
    check("ferr_flag", fe8, 32'h1);
    drive(8, 1'b0, 2 * BIT_CLK);
    check("ferr_held_low", v8, 32'd3);
    drive(8, 1'b1, BIT_CLK);
    send(8, 8, 9'h012, even_par(9'h012), 1, 2'b11);
    drive(8, 1'b1, BIT_CLK);
    check("12_count", v8, 32'd4);
    check("12_data", data_out8, 32'h12);
    check("12_ferr", fe8, 32'h0);

    // break: line low for 20 bit times
    drive(8, 1'b0, 20 * BIT_CLK);
    check("brk_pulses", b8, 32'd1);
    check("brk_no_valid", v8, 32'd4);
    check("brk_data_held", data_out8, 32'h12);
    drive(8, 1'b1, BIT_CLK);
    send(8, 8, 9'h001, even_par(9'h001), 1, 2'b11);
    drive(8, 1'b1, BIT_CLK);
    check("01_count", v8, 32'd5);
    check("01_data", data_out8, 32'h01);
    check("01_ferr", fe8, 32'h0);

`ifdef UART_RX_PARITY_EN
    send(8, 8, 9'h007, 1'b0, 1, 2'b11);
    drive(8, 1'b1, BIT_CLK);
    check("par_bad_count", v8, 32'd6);
    check("par_bad_flag", pe8, 32'h1);
    send(8, 8, 9'h007, 1'b1, 1, 2'b11);
    drive(8, 1'b1, BIT_CLK);
    check("par_ok_flag", pe8, 32'h0);
    check("par_ok_data", data_out8, 32'h07);
`endif

    // 9-bit, two stop bits
    send(9, 9, 9'h1FF, even_par(9'h1FF), 2, 2'b11);
    drive(9, 1'b1, BIT_CLK);
    check("1ff_count", v9, 32'd1);
    check("1ff_data", data_out9, 32'h1FF);
    check("1ff_ferr", fe9, 32'h0);
    send(9, 9, 9'h0F0, even_par(9'h0F0), 2, 2'b01);
    drive(9, 1'b1, BIT_CLK);
    check("stop2_count", v9, 32'd2);
    check("stop2_ferr", fe9, 32'h1);
    check("stop2_data", data_out9, 32'h0F0);

    // reset mid-frame
    drive(9, 1'b0, BIT_CLK);
    drive(9, 1'b1, BIT_CLK);
    drive(9, 1'b0, BIT_CLK / 2);
    reset_n9 = 1'b0;
    rx9 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_data", data_out9, 32'h0);
    check("midrst_valid", rx_valid9, 32'h0);
    check("midrst_ferr", frame_err9, 32'h0);
    check("midrst_brk", break_det9, 32'h0);
    reset_n9 = 1'b1;
    drive(9, 1'b1, 15 * BIT_CLK);
    check("midrst_no_pulse", v9, 32'd2);
    check("midrst_no_brk", b9, 32'd0);
    send(9, 9, 9'h155, even_par(9'h155), 2, 2'b11);
    drive(9, 1'b1, BIT_CLK);
    check("155_count", v9, 32'd3);
    check("155_data", data_out9, 32'h155);
    check("155_ferr", fe9, 32'h0);

    check("width9", long9, 32'h0);
    check("stray8", stray8, 32'h0);
    check("stray9", stray9, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
